// File: rtl/read_rw_pkg.sv
// read_rw_pkg: shared types and register map for the read_rw stage.
//   task_desc_t  - task descriptor (timestamp, locale, type)
//   rw_read_t    - task entering read_rw (task_desc, cq_slot, thread)
//   rw_write_t   - task leaving read_rw towards the RW write stage (+ object word)
//   reg_bus_t    - config/status bus request (write strobe, read strobe, addr, wdata)
package read_rw_pkg;

  localparam int CQ_SLOT_W  = 6;
  localparam int THREAD_W   = 4;
  localparam int REG_ADDR_W = 16;

  typedef struct packed {
    logic [31:0] timestamp;
    logic [31:0] locale;
    logic [3:0]  ttype;
  } task_desc_t;

  typedef struct packed {
    task_desc_t            task_desc;
    logic [CQ_SLOT_W-1:0]  cq_slot;
    logic [THREAD_W-1:0]   thread;
  } rw_read_t;

  typedef struct packed {
    task_desc_t            task_desc;
    logic [CQ_SLOT_W-1:0]  cq_slot;
    logic [THREAD_W-1:0]   thread;
    logic [31:0]           object;
  } rw_write_t;

  typedef struct packed {
    logic                  wvalid;
    logic                  arvalid;
    logic [REG_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } reg_bus_t;

  localparam logic [REG_ADDR_W-1:0] RW_BASE_ADDR        = 16'h0040;
  localparam logic [REG_ADDR_W-1:0] RW_READ_STATUS      = 16'h0100;
  localparam logic [REG_ADDR_W-1:0] RW_READ_STAT_REQS   = 16'h0104;
  localparam logic [REG_ADDR_W-1:0] RW_READ_STAT_STALLS = 16'h0108;

endpackage

// File: rtl/read_rw_if.sv
// read_rw_if: bundles every non-clock signal of the read_rw stage.
//   task_in_*   - upstream task handshake
//   ar* / r*    - read request / response towards the RW data array
//   task_out_*  - downstream handshake to the RW write stage
//   pending_cnt, resp_err - status
//   reg_req / reg_rvalid / reg_rdata - config/status register bus
// Modports: slave = read_rw's view, master = the surrounding system's view.
interface read_rw_if #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LOG_OUT         = $clog2(MAX_OUTSTANDING)
) ();
  import read_rw_pkg::*;

  logic             task_in_valid;
  logic             task_in_ready;
  rw_read_t         task_in;
  logic             arvalid;
  logic             arready;
  logic [31:0]      araddr;
  logic             rvalid;
  logic             rready;
  logic [511:0]     rdata;
  logic             task_out_valid;
  logic             task_out_ready;
  rw_write_t        task_out;
  logic [LOG_OUT:0] pending_cnt;
  logic             resp_err;
  reg_bus_t         reg_req;
  logic             reg_rvalid;
  logic [31:0]      reg_rdata;

  modport slave (
    input  task_in_valid, task_in, arready, rvalid, rdata, task_out_ready, reg_req,
    output task_in_ready, arvalid, araddr, rready, task_out_valid, task_out,
           pending_cnt, resp_err, reg_rvalid, reg_rdata
  );

  modport master (
    output task_in_valid, task_in, arready, rvalid, rdata, task_out_ready, reg_req,
    input  task_in_ready, arvalid, araddr, rready, task_out_valid, task_out,
           pending_cnt, resp_err, reg_rvalid, reg_rdata
  );

endinterface

// File: rtl/read_rw_pending_fifo.sv
// read_rw_pending_fifo: synchronous FIFO holding tasks whose data-array read
// is still in flight. Head is visible combinationally.
//   clk, rst     - clock, asynchronous active-high reset (pointers/count only)
//   push_i       - write push_data_i (ignored when full)
//   pop_i        - drop the head entry (ignored when empty)
//   head_o       - oldest entry
//   full_o, empty_o, count_o - occupancy
module read_rw_pending_fifo import read_rw_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int LOG_D = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  rw_read_t       push_data_i,
  input  logic           pop_i,
  output rw_read_t       head_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [LOG_D:0] count_o
);

  rw_read_t         mem_q [DEPTH];
  logic [LOG_D-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_D-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_D:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (LOG_D+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is payload only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/read_rw.sv
// read_rw: issues a read of each task's locale word from the RW data array and
// forwards the task plus the returned 32-bit object to the RW write stage.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - read_rw_if.slave: task_in, ar/r read channel, task_out,
//              pending_cnt, resp_err, register bus
// Register map: RW_BASE_ADDR (W), RW_READ_STATUS (R: {resp_err, pending_cnt}).
// Optional macro RW_READ_STATS_EN adds request/stall counters at
// RW_READ_STAT_REQS / RW_READ_STAT_STALLS (write either to clear both).
module read_rw import read_rw_pkg::*; #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LOG_OUT         = $clog2(MAX_OUTSTANDING)
) (
  input logic      clk,
  input logic      rst,
  read_rw_if.slave bus
);

  logic             fifo_full, fifo_empty;
  logic [LOG_OUT:0] fifo_cnt;
  rw_read_t         head;
  logic             push, pop;

  logic [31:0]      base_q, base_d;
  logic             out_valid_q, out_valid_d;
  rw_write_t        out_q;
  logic             resp_err_q, resp_err_d;
  logic             reg_rvalid_q;
  logic [31:0]      reg_rdata_q;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  function automatic logic [31:0] pick_word(input logic [511:0] line,
                                            input logic [3:0]   idx);
    return line[{idx, 5'd0} +: 32];
  endfunction

  // Request path: purely combinational so a task and its read go out together.
  assign bus.arvalid       = bus.task_in_valid & ~fifo_full;
  assign bus.araddr        = base_q + (bus.task_in.task_desc.locale << 2);
  assign bus.task_in_ready = bus.arvalid & bus.arready;
  assign push              = bus.task_in_ready;

  // A response is only taken when it has a matching task and somewhere to go.
  assign bus.rready = ~fifo_empty & (~out_valid_q | bus.task_out_ready);
  assign pop        = bus.rvalid & bus.rready;

  read_rw_pending_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .LOG_D (LOG_OUT)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (bus.task_in),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    base_d = base_q;
    if (bus.reg_req.wvalid && bus.reg_req.addr == RW_BASE_ADDR)
      base_d = {bus.reg_req.wdata[29:0], 2'b00};
    out_valid_d = out_valid_q;
    if (pop)
      out_valid_d = 1'b1;
    else if (bus.task_out_ready)
      out_valid_d = 1'b0;
    resp_err_d = resp_err_q | (bus.rvalid & fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      out_valid_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      reg_rvalid_q <= 1'b0;
    end else begin
      base_q       <= base_d;
      out_valid_q  <= out_valid_d;
      resp_err_q   <= resp_err_d;
      reg_rvalid_q <= bus.reg_req.arvalid;
    end
  end

  // Output payload and register read data carry no reset; valids qualify them.
  always_ff @(posedge clk) begin
    if (pop) begin
      out_q.task_desc <= head.task_desc;
      out_q.cq_slot   <= head.cq_slot;
      out_q.thread    <= head.thread;
      out_q.object    <= pick_word(bus.rdata, head.task_desc.locale[3:0]);
    end
    if (bus.reg_req.arvalid) reg_rdata_q <= rd_mux;
  end

`ifdef RW_READ_STATS_EN
  logic [31:0] reqs_q, stalls_q;
  logic        stat_clr;

  assign stat_clr = bus.reg_req.wvalid &&
                    (bus.reg_req.addr == RW_READ_STAT_REQS ||
                     bus.reg_req.addr == RW_READ_STAT_STALLS);

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqs_q   <= '0;
      stalls_q <= '0;
    end else if (stat_clr) begin
      reqs_q   <= '0;
      stalls_q <= '0;
    end else begin
      if (bus.arvalid && bus.arready)        reqs_q   <= reqs_q + 1'b1;
      if (bus.task_in_valid && fifo_full)    stalls_q <= stalls_q + 1'b1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (bus.reg_req.addr == RW_READ_STATUS)
      rd_mux[LOG_OUT+1:0] = {resp_err_q, fifo_cnt};
`ifdef RW_READ_STATS_EN
    else if (bus.reg_req.addr == RW_READ_STAT_REQS)
      rd_mux = reqs_q;
    else if (bus.reg_req.addr == RW_READ_STAT_STALLS)
      rd_mux = stalls_q;
`endif
  end

  assign unused_wdata = ^bus.reg_req.wdata[31:30];

  assign bus.task_out_valid = out_valid_q;
  assign bus.task_out       = out_q;
  assign bus.pending_cnt    = fifo_cnt;
  assign bus.resp_err       = resp_err_q;
  assign bus.reg_rvalid     = reg_rvalid_q;
  assign bus.reg_rdata      = reg_rdata_q;

endmodule

// File: tb/tb_read_rw.sv
// tb_read_rw: directed scenarios plus randomized traffic for read_rw, checked
// every cycle against a queue-based reference model of the stage.
module tb_read_rw;
  import read_rw_pkg::*;

  localparam int MAX_OUTSTANDING = 4;
  localparam int LOG_OUT         = $clog2(MAX_OUTSTANDING);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  read_rw_if #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .LOG_OUT(LOG_OUT)) bus ();

  read_rw #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .LOG_OUT(LOG_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  rw_read_t    m_q[$];
  logic        m_vld = 1'b0;
  rw_write_t   m_out;
  logic        m_err = 1'b0;
  logic [31:0] m_base = '0;
`ifdef RW_READ_STATS_EN
  logic [31:0] m_reqs = '0;
  logic [31:0] m_stalls = '0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    logic [31:0] v;
    v = '0;
    if (a == RW_READ_STATUS)
      v = (32'(m_err) << (LOG_OUT + 1)) | 32'(m_q.size());
`ifdef RW_READ_STATS_EN
    else if (a == RW_READ_STAT_REQS)   v = m_reqs;
    else if (a == RW_READ_STAT_STALLS) v = m_stalls;
`endif
    return v;
  endfunction

  function automatic rw_read_t mk_task(input logic [31:0] loc);
    rw_read_t t;
    t.task_desc.timestamp = $urandom;
    t.task_desc.locale    = loc;
    t.task_desc.ttype     = 4'($urandom);
    t.cq_slot             = 6'($urandom);
    t.thread              = 4'($urandom);
    return t;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One clock cycle with the inputs as currently driven: check combinational
  // outputs, advance the model, cross the edge, check registered outputs.
  task automatic cycle();
    logic        e_arv, e_rdy, e_rr, rd;
    logic [31:0] e_rd, e_addr;
    rw_read_t    t;
    #1;
    e_arv  = bus.task_in_valid && (m_q.size() < MAX_OUTSTANDING);
    e_rdy  = e_arv && bus.arready;
    e_rr   = (m_q.size() > 0) && (!m_vld || bus.task_out_ready);
    e_addr = m_base + bus.task_in.task_desc.locale * 4;
    chk("arvalid", bus.arvalid, e_arv);
    chk("task_in_ready", bus.task_in_ready, e_rdy);
    chk("rready", bus.rready, e_rr);
    if (e_arv) chk("araddr", bus.araddr, e_addr);
    rd   = bus.reg_req.arvalid;
    e_rd = m_read(bus.reg_req.addr);

`ifdef RW_READ_STATS_EN
    if (bus.reg_req.wvalid && (bus.reg_req.addr == RW_READ_STAT_REQS ||
                               bus.reg_req.addr == RW_READ_STAT_STALLS)) begin
      m_reqs = 0; m_stalls = 0;
    end else begin
      if (e_rdy) m_reqs++;
      if (bus.task_in_valid && m_q.size() == MAX_OUTSTANDING) m_stalls++;
    end
`endif
    if (bus.rvalid && m_q.size() == 0) m_err = 1'b1;
    if (bus.rvalid && e_rr) begin
      t = m_q.pop_front();
      m_out.task_desc = t.task_desc;
      m_out.cq_slot   = t.cq_slot;
      m_out.thread    = t.thread;
      m_out.object    = 32'(bus.rdata >> (32 * (t.task_desc.locale % 16)));
      m_vld = 1'b1;
    end else if (bus.task_out_ready) begin
      m_vld = 1'b0;
    end
    if (e_rdy) m_q.push_back(bus.task_in);
    if (bus.reg_req.wvalid && bus.reg_req.addr == RW_BASE_ADDR)
      m_base = bus.reg_req.wdata * 4;

    @(posedge clk); #1;
    chk("task_out_valid", bus.task_out_valid, m_vld);
    chk("pending_cnt", bus.pending_cnt, m_q.size());
    chk("resp_err", bus.resp_err, m_err);
    chk("reg_rvalid", bus.reg_rvalid, rd);
    if (m_vld) chk("task_out", bus.task_out, m_out);
    if (rd) chk("reg_rdata", bus.reg_rdata, e_rd);
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [31:0] d);
    bus.reg_req.wvalid = 1'b1;
    bus.reg_req.addr   = a;
    bus.reg_req.wdata  = d;
    cycle();
    bus.reg_req.wvalid = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [31:0] d);
    bus.reg_req.arvalid = 1'b1;
    bus.reg_req.addr    = a;
    cycle();
    bus.reg_req.arvalid = 1'b0;
    d = bus.reg_rdata;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_base = '0;
`ifdef RW_READ_STATS_EN
    m_reqs = '0; m_stalls = '0;
`endif
  endtask

  task automatic rand_cycles(input int n);
    logic [15:0] addrs [4];
    addrs[0] = RW_READ_STATUS; addrs[1] = RW_READ_STAT_REQS;
    addrs[2] = RW_READ_STAT_STALLS; addrs[3] = 16'h0200;
    for (int i = 0; i < n; i++) begin
      bus.task_in_valid  = $urandom_range(0, 3) != 0;
      bus.task_in        = mk_task($urandom);
      bus.arready        = $urandom_range(0, 3) != 0;
      bus.rvalid         = $urandom_range(0, 2) != 0;
      bus.rdata          = rand_line();
      bus.task_out_ready = $urandom_range(0, 3) != 0;
      bus.reg_req.wvalid  = 1'b0;
      bus.reg_req.arvalid = 1'b0;
      case ($urandom_range(0, 15))
        0: begin bus.reg_req.wvalid = 1'b1; bus.reg_req.addr = RW_BASE_ADDR;
                 bus.reg_req.wdata = $urandom; end
        1, 2: begin bus.reg_req.arvalid = 1'b1; bus.reg_req.addr = addrs[$urandom_range(0, 3)]; end
        3: if ($urandom_range(0, 3) == 0) begin
             bus.reg_req.wvalid = 1'b1; bus.reg_req.addr = addrs[$urandom_range(1, 2)];
             bus.reg_req.wdata = $urandom;
           end
        default: ;
      endcase
      cycle();
    end
    bus.reg_req.wvalid  = 1'b0;
    bus.reg_req.arvalid = 1'b0;
  endtask

  initial begin
    logic [511:0] line;
    logic [31:0]  d;
    logic [31:0]  t3_exp [4];
    logic [31:0]  t3_loc [4];

    bus.task_in_valid  = 1'b0;
    bus.task_in        = mk_task(0);
    bus.arready        = 1'b0;
    bus.rvalid         = 1'b0;
    bus.rdata          = '0;
    bus.task_out_ready = 1'b0;
    bus.reg_req        = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_task_out_valid", bus.task_out_valid, 1'b0);
    chk("rst_pending_cnt", bus.pending_cnt, 0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    chk("rst_reg_rvalid", bus.reg_rvalid, 1'b0);
    rst = 1'b0;

    // 1: single task, base 0x1000, locale 5
    reg_wr(RW_BASE_ADDR, 32'h0000_0400);
    bus.task_out_ready = 1'b1;
    bus.arready        = 1'b1;
    bus.task_in_valid  = 1'b1;
    bus.task_in        = mk_task(5);
    #1 chk("t1_araddr", bus.araddr, 32'h0000_1014);
    cycle();
    bus.task_in_valid = 1'b0;
    line = rand_line();
    line[5*32 +: 32] = 32'h77;
    bus.rdata  = line;
    bus.rvalid = 1'b1;
    cycle();
    bus.rvalid = 1'b0;
    chk("t1_object", bus.task_out.object, 32'h77);
    cycle();

    // 2: fill the FIFO, then a 5th task waits for a response
    bus.task_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.task_in = mk_task($urandom);
      cycle();
    end
    chk("t2_pending_full", bus.pending_cnt, 4);
    bus.task_in = mk_task(32'd9);
    cycle();
    bus.rvalid = 1'b1;
    bus.rdata  = rand_line();
    cycle();
    bus.rvalid = 1'b0;
    #1 chk("t2_fifth_accept", bus.task_in_ready, 1'b1);
    cycle();
    bus.task_in_valid = 1'b0;
    bus.rvalid = 1'b1;
    repeat (4) begin
      bus.rdata = rand_line();
      cycle();
    end
    bus.rvalid = 1'b0;
    cycle();

    // 3: back-to-back responses, locales 0,15,16,31
    t3_loc[0] = 0; t3_loc[1] = 15; t3_loc[2] = 16; t3_loc[3] = 31;
    t3_exp[0] = 32'h100; t3_exp[1] = 32'h10f; t3_exp[2] = 32'h100; t3_exp[3] = 32'h10f;
    bus.task_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.task_in = mk_task(t3_loc[i]);
      cycle();
    end
    bus.task_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'h100 + i;
    bus.rdata  = line;
    bus.rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_object", bus.task_out.object, t3_exp[i]);
      chk("t3_valid", bus.task_out_valid, 1'b1);
    end
    bus.rvalid = 1'b0;
    cycle();

    // 4: downstream back-pressure holds the output and blocks responses
    bus.task_in_valid = 1'b1;
    repeat (2) begin
      bus.task_in = mk_task($urandom);
      cycle();
    end
    bus.task_in_valid = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = rand_line();
    cycle();
    bus.task_out_ready = 1'b0;
    repeat (3) begin
      bus.rdata = rand_line();
      cycle();
    end
    bus.task_out_ready = 1'b1;
    cycle();
    bus.rvalid = 1'b0;
    repeat (2) cycle();

    // 5: response with nothing pending
    bus.rvalid = 1'b1;
    cycle();
    bus.rvalid = 1'b0;
    cycle();
    reg_rd(RW_READ_STATUS, d);
    chk("t5_status_err_bit", d[LOG_OUT+1], 1'b1);
    chk("t5_resp_err_sticky", bus.resp_err, 1'b1);

`ifdef RW_READ_STATS_EN
    // 6: counters
    bus.task_in_valid = 1'b1;
    bus.task_in = mk_task($urandom);
    cycle();
    bus.task_in_valid = 1'b0;
    reg_wr(RW_READ_STAT_STALLS, 32'h0);
    bus.task_in_valid = 1'b1;
    repeat (3) begin
      bus.task_in = mk_task($urandom);
      cycle();
    end
    repeat (2) cycle();
    bus.task_in_valid = 1'b0;
    reg_rd(RW_READ_STAT_REQS, d);
    chk("t6_reqs", d, 32'd3);
    reg_rd(RW_READ_STAT_STALLS, d);
    chk("t6_stalls", d, 32'd2);
    reg_wr(RW_READ_STAT_REQS, 32'hdead_beef);
    reg_rd(RW_READ_STAT_REQS, d);
    chk("t6_reqs_clr", d, 32'd0);
    reg_rd(RW_READ_STAT_STALLS, d);
    chk("t6_stalls_clr", d, 32'd0);
    bus.rvalid = 1'b1;
    repeat (4) begin
      bus.rdata = rand_line();
      cycle();
    end
    bus.rvalid = 1'b0;
    cycle();
`else
    reg_rd(RW_READ_STAT_REQS, d);
    chk("nostats_reqs_zero", d, 32'd0);
`endif

    // Randomized traffic
    rand_cycles(400);

    // Reset in the middle of traffic, asserted between clock edges
    bus.task_in_valid  = 1'b1;
    bus.arready        = 1'b1;
    bus.task_out_ready = 1'b0;
    bus.rvalid         = 1'b0;
    repeat (2) begin
      bus.task_in = mk_task($urandom);
      cycle();
    end
    bus.task_in_valid = 1'b0;
    if (m_vld == 1'b0) begin
      bus.rvalid = 1'b1;
      bus.rdata  = rand_line();
      cycle();
      bus.rvalid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_task_out_valid", bus.task_out_valid, 1'b0);
    chk("arst_pending_cnt", bus.pending_cnt, 0);
    chk("arst_resp_err", bus.resp_err, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.task_out_ready = 1'b1;
    reg_rd(RW_READ_STATUS, d);
    chk("arst_status_zero", d, 32'd0);

    rand_cycles(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
